// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-port memory bus between the instruction-fetch
//             requester (IF) and the MEM-stage data requester. Each access is
//             a bus_req/bus_ack transaction. Completion is a one-cycle ready
//             pulse. MEM has priority over IF, bounded by a starvation limit.
//             A bus timeout aborts any access that is never acknowledged.
//  Ports    : clk, rst (synchronous, active-low)
//             IF side   : if_req, if_addr -> if_rdata, if_ready, stall_if
//             MEM side  : mem_read, mem_write, mem_addr, mem_wdata
//                         -> mem_rdata, mem_ready, stall_mem
//             Bus side  : bus_req, bus_we, bus_addr, bus_wdata
//                         <- bus_rdata, bus_ack
//             Errors    : bus_err (timeout pulse), proto_err (read+write pulse)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // MEM-stage data requester
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  // unified memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  // pipeline stalls and error pulses
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err,
  output logic              proto_err
);

  localparam int unsigned C_CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned C_STRK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_STRK_W-1:0] C_STRK_MAX = C_STRK_W'(MAX_MEM_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t              state_q,     state_d;
  owner_t              owner_q,     owner_d;
  logic                bus_req_q,   bus_req_d;
  logic                bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ready_q,  if_ready_d;
  logic                mem_ready_q, mem_ready_d;
  logic                bus_err_q,   bus_err_d;
  logic                proto_err_q, proto_err_d;
  logic [C_CNT_W-1:0]  cnt_q,       cnt_d;
  logic [C_STRK_W-1:0] streak_q,    streak_d;

  logic w_mem_any;
  logic w_grant_mem;

  assign w_mem_any   = mem_read | mem_write;
  // MEM wins unless IF has already watched MAX_MEM_STREAK MEM grants go by.
  assign w_grant_mem = w_mem_any & ~(if_req & (streak_q == C_STRK_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;
    proto_err_d = 1'b0;
    cnt_d       = cnt_q;
    streak_d    = streak_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_mem) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_MEM;
          bus_req_d   = 1'b1;
          // Read and write together is treated as a write.
          bus_we_d    = mem_write;
          bus_addr_d  = mem_addr;
          if (mem_write) begin
            bus_wdata_d = mem_wdata;
          end
          proto_err_d = mem_read & mem_write;
          cnt_d       = '0;
          if (if_req) begin
            streak_d = (streak_q == C_STRK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d    = ST_BUSY;
          owner_d    = OWN_IF;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          cnt_d      = '0;
          streak_d   = '0;
        end else begin
          streak_d = '0;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the final allowed cycle still completes normally.
        if (bus_ack) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            if (owner_q == OWN_MEM) begin
              mem_rdata_d = bus_rdata;
            end else begin
              if_rdata_d = bus_rdata;
            end
          end
          mem_ready_d = (owner_q == OWN_MEM);
          if_ready_d  = (owner_q == OWN_IF);
        end else if (cnt_q == C_CNT_LAST) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
          mem_ready_d = (owner_q == OWN_MEM);
          if_ready_d  = (owner_q == OWN_IF);
        end
      end

      ST_RESP: begin
        // Ready is visible this cycle; the requester updates its request
        // before the next IDLE arbitration.
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;
  assign proto_err = proto_err_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = w_mem_any & ~mem_ready_q;

endmodule
`default_nettype wire
